mux_2x1_arbiter: RTL and testbench

- Shares one mux_2x1 datapath between two requesters, A and B, using round-robin arbitration.
- The winning requester's data passes through the mux into a one-entry output register, which is drained by a consumer over a valid/ready handshake.
- Sits in front of any shared 8-bit resource fed through mux_2x1. The block owns the mux select; no other logic drives s.

---
 rtl/mux_2x1_arbiter_pkg.sv | 6 +
 rtl/mux_2x1.sv | 11 +
 rtl/mux_2x1_arbiter_dp.sv | 13 +
 rtl/mux_2x1_arbiter.sv | 48 ++++
 tb/tb_mux_2x1_arbiter.sv | 121 ++++++++++++
 5 files changed

// File: rtl/mux_2x1_arbiter_pkg.sv
// mux_2x1_arbiter_pkg: default widths and output-slot state encoding shared by the arbiter slice
package mux_2x1_arbiter_pkg;
  localparam int P_DEF = 7;
  localparam int CW_DEF = 8;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: 2:1 mux, y = s ? a : b (ports a, b [p:0]; s; y [p:0])
module mux_2x1 #(
  parameter int p = 7
) (
  input  logic [p:0] a,
  input  logic [p:0] b,
  input  logic       s,
  output logic [p:0] y
);
  assign y = s ? a : b;
endmodule

// File: rtl/mux_2x1_arbiter_dp.sv
// mux_2x1_arbiter_dp: datapath wrapping mux_2x1, y = s ? data_a : data_b (ports data_a, data_b, s, y)
module mux_2x1_arbiter_dp
  import mux_2x1_arbiter_pkg::*;
#(
  parameter int p = P_DEF
) (
  input  logic [p:0] data_a,
  input  logic [p:0] data_b,
  input  logic       s,
  output logic [p:0] y
);
  mux_2x1 #(.p(p)) u_mux (.a(data_a), .b(data_b), .s(s), .y(y));
endmodule

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: round-robin share of mux_2x1 between req_a/req_b into a one-entry out/out_valid/out_ready slot, with gnt_a/gnt_b, cnt_a/cnt_b grant counters and last_a
module mux_2x1_arbiter
  import mux_2x1_arbiter_pkg::*;
#(
  parameter int p  = P_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [p:0]    data_a,
  input  logic          req_b,
  input  logic [p:0]    data_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [p:0]    out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic          last_a
);
  state_t state;
  logic load_en;
  logic [p:0] out_d;
  assign out_valid = state == FULL;
  assign load_en = !out_valid | out_ready;
  assign gnt_a = !rst & load_en & req_a & (!req_b | !last_a);
  assign gnt_b = !rst & load_en & req_b & (!req_a | last_a);
  mux_2x1_arbiter_dp #(.p(p)) u_dp (.data_a(data_a), .data_b(data_b), .s(gnt_a), .y(out_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      out    <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      last_a <= 1'b0;
    end else if (gnt_a | gnt_b) begin
      state  <= FULL;
      out    <= out_d;
      last_a <= gnt_a;
      cnt_a  <= cnt_a + CW'(gnt_a);
      cnt_b  <= cnt_b + CW'(gnt_b);
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb_mux_2x1_arbiter: vector table plus reference model and scoreboard for mux_2x1_arbiter
module tb_mux_2x1_arbiter;
  logic clk = 0, rst = 1, req_a = 0, req_b = 0, out_ready = 0;
  logic [7:0] data_a = 0, data_b = 0, out;
  logic gnt_a, gnt_b, out_valid, last_a;
  logic [7:0] cnt_a, cnt_b;
  int n_tests = 0, n_fail = 0;
  logic m_valid = 0, m_last = 0, m_rs = 0;
  logic [7:0] m_out = 0, m_ca = 0, m_cb = 0;
  logic [7:0] sb[$];
  logic sga, sgb;
  typedef struct {
    logic rs, ra; logic [7:0] da; logic rb; logic [7:0] db; logic rdy;
    logic ega, egb; logic [7:0] eo; logic ev;
  } vec_t;
  vec_t tbl[$];

  mux_2x1_arbiter #(.p(7), .CW(8)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .last_a(last_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called #1 after a rising edge; returns the grants seen during the cycle.
  task automatic step(input logic rs, input logic ra, input logic [7:0] da, input logic rb,
                      input logic [7:0] db, input logic rdy, output logic ga, output logic gb);
    logic ld, mga, mgb;
    logic [7:0] w;
    rst = rs; req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
    #1;
    ld  = !m_valid | rdy;
    mga = !rs & ld & ra & (!rb | !m_last);
    mgb = !rs & ld & rb & (!ra | m_last);
    ga = gnt_a; gb = gnt_b;
    chk("gnt_a", gnt_a, mga);
    chk("gnt_b", gnt_b, mgb);
    if (m_valid && rdy && !rs) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        w = sb.pop_front();
        chk("sb_out", out, w);
      end
    end
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_out = 0; m_ca = 0; m_cb = 0; m_last = 0; sb.delete();
    end else if (mga | mgb) begin
      m_out = mga ? da : db; m_valid = 1; m_last = mga;
      m_ca += 8'(mga); m_cb += 8'(mgb);
      sb.push_back(m_out);
    end else if (rdy) m_valid = 0;
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("cnt_a", cnt_a, m_ca);
    chk("cnt_b", cnt_b, m_cb);
    chk("last_a", last_a, m_last);
    if (m_valid || rs) chk("out", out, m_out);
  endtask

  initial begin
    logic ra, rb, rdy;
    logic [7:0] da, db;
    // first row: single A request right after reset
    tbl.push_back('{0,1,8'h3C,0,8'h00,1, 1,0,8'h3C,1});
    tbl.push_back('{1,1,8'hAA,1,8'h55,1, 0,0,8'h00,0});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 1,0,8'hAA,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 0,1,8'h55,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 1,0,8'hAA,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 0,1,8'h55,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 1,0,8'hAA,1});
    for (int i = 0; i < 3; i++) tbl.push_back('{0,1,8'hAA,1,8'h55,0, 0,0,8'hAA,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 0,1,8'h55,1});
    tbl.push_back('{0,0,8'hAA,0,8'h55,1, 0,0,8'h55,0});
    tbl.push_back('{0,0,8'hAA,0,8'h55,1, 0,0,8'h55,0});
    tbl.push_back('{0,0,8'hAA,0,8'h55,0, 0,0,8'h55,0});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 1,0,8'hAA,1});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 0,1,8'h55,1});
    tbl.push_back('{1,1,8'hAA,1,8'h55,1, 0,0,8'h00,0});
    tbl.push_back('{0,1,8'hAA,1,8'h55,1, 1,0,8'hAA,1});
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, sga, sgb);
    step(1, 1, 8'h11, 1, 8'h22, 1, sga, sgb);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rs, tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].rdy, sga, sgb);
      chk($sformatf("tbl%0d_gnt_a", i), sga, tbl[i].ega);
      chk($sformatf("tbl%0d_gnt_b", i), sgb, tbl[i].egb);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev || tbl[i].rs) chk($sformatf("tbl%0d_out", i), out, tbl[i].eo);
    end
    // 256 B-only grants wrap cnt_b back to 0
    step(1, 0, 0, 0, 0, 1, sga, sgb);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 8'h00, 1, 8'(i * 7 + 3), 1, sga, sgb);
      if (i == 254) chk("cnt_b_255", cnt_b, 8'd255);
    end
    chk("cnt_b_wrap", cnt_b, 8'd0);
    chk("cnt_a_zero", cnt_a, 8'd0);
    // random traffic with requests held until granted
    ra = 0; rb = 0; da = 0; db = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ra) begin ra = 1'($urandom_range(0, 1)); da = 8'($urandom); end
      if (!rb) begin rb = 1'($urandom_range(0, 1)); db = 8'($urandom); end
      rdy = 1'($urandom_range(0, 3) != 0);
      step(0, ra, da, rb, db, rdy, sga, sgb);
      if (sga) ra = 0;
      if (sgb) rb = 0;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
